// File: rtl/vaelix_key_conditioner.sv
// rtl/vaelix_key_conditioner.sv - debounced DIP-switch key entry with verdict tracking and lockout
// Presents the debounced switch key on each commit and locks out after MAX_FAILS failed attempts.
module vaelix_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_FAILS       = 3,
  parameter int VERDICT_TIMEOUT = 8,
  parameter int LOCKOUT_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] sw_in,
  input  logic       commit_btn,
  input  logic       auth_pass,
  input  logic       auth_fail,
  output logic [7:0] key_out,
  output logic       key_valid,
  output logic       lockout,
  output logic [1:0] fail_count
);

  localparam int TW = $clog2(VERDICT_TIMEOUT + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [7:0]    DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]    DEB_MAX    = 8'(DEBOUNCE_CYCLES);
  localparam logic [1:0]    FAIL_LIMIT = 2'(MAX_FAILS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(VERDICT_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [LW-1:0] LOCK_LOAD  = LW'(LOCKOUT_CYCLES);
  localparam logic [LW-1:0] LOCK_ONE   = LW'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_WAIT = 3'b010,
    S_LOCK = 3'b100
  } state_t;

  logic [7:0]    sw_s1, sw_s2, sw_prev, sw_cnt, sw_deb;
  logic          btn_s1, btn_s2, btn_prev, btn_deb;
  logic [7:0]    btn_cnt;
  logic          btn_armed, commit_evt;
  logic          sw_hit, btn_hit;
  state_t        state;
  logic [TW-1:0] timer;
  logic [LW-1:0] lock_cnt;
  logic          key_valid_q;
  logic          verdict_fail;
  logic [1:0]    fails_next;

  // A hit is the edge on which a stability counter reaches DEBOUNCE_CYCLES.
  assign sw_hit  = (sw_s2 == sw_prev) && (sw_cnt == DEB_LAST);
  assign btn_hit = (btn_s2 == btn_prev) && (btn_cnt == DEB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1      <= 8'h00;
      sw_s2      <= 8'h00;
      sw_prev    <= 8'h00;
      sw_cnt     <= 8'h00;
      sw_deb     <= 8'h00;
      btn_s1     <= 1'b0;
      btn_s2     <= 1'b0;
      btn_prev   <= 1'b0;
      btn_cnt    <= 8'h00;
      btn_deb    <= 1'b0;
      btn_armed  <= 1'b0;
      commit_evt <= 1'b0;
    end else if (ena) begin
      sw_s1   <= sw_in;
      sw_s2   <= sw_s1;
      sw_prev <= sw_s2;
      if (sw_s2 != sw_prev)
        sw_cnt <= 8'h00;
      else if (sw_cnt != DEB_MAX)
        sw_cnt <= sw_cnt + 8'd1;
      if (sw_hit)
        sw_deb <= sw_s2;

      btn_s1   <= commit_btn;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
      if (btn_s2 != btn_prev)
        btn_cnt <= 8'h00;
      else if (btn_cnt != DEB_MAX)
        btn_cnt <= btn_cnt + 8'd1;
      if (btn_hit)
        btn_deb <= btn_s2;
      // A button held through reset must be seen released before it can commit.
      if (btn_hit && !btn_s2)
        btn_armed <= 1'b1;
      commit_evt <= btn_hit && btn_s2 && !btn_deb && btn_armed;
    end
  end

  // A verdict pulse wins over a timeout landing on the same edge.
  assign verdict_fail = auth_fail || (!auth_pass && (timer == TIMER_LAST));
  assign fails_next   = fail_count + 2'd1;
  assign key_valid    = key_valid_q & ena;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      key_out     <= 8'h00;
      key_valid_q <= 1'b0;
      lockout     <= 1'b0;
      fail_count  <= 2'd0;
      timer       <= '0;
      lock_cnt    <= '0;
    end else if (!ena) begin
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (commit_evt) begin
            key_out     <= sw_deb;
            key_valid_q <= 1'b1;
            timer       <= '0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (verdict_fail) begin
            fail_count <= fails_next;
            if (fails_next == FAIL_LIMIT) begin
              state    <= S_LOCK;
              key_out  <= 8'h00;
              lockout  <= 1'b1;
              lock_cnt <= LOCK_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end else if (auth_pass) begin
            fail_count <= 2'd0;
            state      <= S_IDLE;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        S_LOCK: begin
          if (lock_cnt == LOCK_ONE) begin
            state      <= S_IDLE;
            lockout    <= 1'b0;
            fail_count <= 2'd0;
          end else begin
            lock_cnt <= lock_cnt - LOCK_ONE;
          end
        end
        default: begin
          state    <= S_LOCK;
          key_out  <= 8'h00;
          lockout  <= 1'b1;
          lock_cnt <= LOCK_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vaelix_key_conditioner.sv
// tb/tb_vaelix_key_conditioner.sv - directed and randomized checks of vaelix_key_conditioner
module tb_vaelix_key_conditioner;

  localparam int D  = 4;
  localparam int MF = 3;
  localparam int VT = 8;
  localparam int LC = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] sw_in;
  logic       commit_btn;
  logic       auth_pass;
  logic       auth_fail;
  logic [7:0] key_out;
  logic       key_valid;
  logic       lockout;
  logic [1:0] fail_count;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int kv_count    = 0;
  int t_lock      = 0;

  int         m_fails;
  bit         m_lock;
  logic [7:0] m_key;

  vaelix_key_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .MAX_FAILS(MF),
    .VERDICT_TIMEOUT(VT),
    .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .sw_in(sw_in),
    .commit_btn(commit_btn),
    .auth_pass(auth_pass),
    .auth_fail(auth_fail),
    .key_out(key_out),
    .key_valid(key_valid),
    .lockout(lockout),
    .fail_count(fail_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (key_valid === 1'b1) kv_count <= kv_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_fail_count"}, 32'(fail_count), 32'(m_fails));
    check({tag, "_lockout"}, 32'(lockout), 32'(m_lock));
    check({tag, "_key_out"}, 32'(key_out), 32'(m_key));
  endtask

  task automatic settle_sw(input logic [7:0] v);
    sw_in = v;
    tick(D + 4);
  endtask

  task automatic release_btn();
    commit_btn = 1'b0;
    tick(D + 4);
  endtask

  // Presses the button and returns on the cycle after the key_valid strobe.
  task automatic press_expect_kv(output bit ok);
    int start;
    start = kv_count;
    commit_btn = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < D + 12; i++) begin
      tick(1);
      if (kv_count != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reference rules: pass clears the count, anything else adds one; reaching MF locks out.
  task automatic model_verdict(input int kind);
    if (kind == 0) begin
      m_fails = 0;
    end else begin
      m_fails++;
      if (m_fails == MF) begin
        m_lock = 1'b1;
        m_key  = 8'h00;
        t_lock = cyc;
      end
    end
  endtask

  // kind: 0 pass, 1 fail, 2 pass+fail together, 3 no verdict until timeout
  task automatic verdict(input int kind, input string tag);
    case (kind)
      0: auth_pass = 1'b1;
      1: auth_fail = 1'b1;
      2: begin auth_pass = 1'b1; auth_fail = 1'b1; end
      default: begin
        tick(VT - 2);
        check({tag, "_pre_timeout"}, 32'(fail_count), 32'(m_fails));
      end
    endcase
    tick(1);
    auth_pass = 1'b0;
    auth_fail = 1'b0;
    model_verdict(kind);
    check_outs({tag, "_verdict"});
  endtask

  task automatic commit_round(input logic [7:0] v, input int kind, input string tag);
    int k0;
    bit ok;
    settle_sw(v);
    k0 = kv_count;
    press_expect_kv(ok);
    check({tag, "_kv_seen"}, 32'(ok), 32'd1);
    m_key = v;
    check({tag, "_key"}, 32'(key_out), 32'(m_key));
    verdict(kind, tag);
    release_btn();
    check({tag, "_kv_once"}, 32'(kv_count - k0), 32'd1);
  endtask

  task automatic wait_lock_end(input string tag);
    while (cyc < t_lock + LC - 1) tick(1);
    check({tag, "_lock_last"}, 32'(lockout), 32'd1);
    tick(1);
    m_lock  = 1'b0;
    m_fails = 0;
    check_outs({tag, "_lock_end"});
  endtask

  initial begin
    int k0;
    bit seen;
    logic [7:0] v;

    rst_n      = 1'b0;
    ena        = 1'b1;
    sw_in      = 8'h00;
    commit_btn = 1'b0;
    auth_pass  = 1'b0;
    auth_fail  = 1'b0;
    m_fails    = 0;
    m_lock     = 1'b0;
    m_key      = 8'h00;

    tick(3);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check_outs("rst");
    rst_n = 1'b1;
    tick(D + 4);

    // Long press with pass verdict.
    commit_round(8'hB6, 0, "b6_pass");

    // Short glitch on bit 7 must never reach the debounced switches.
    settle_sw(8'h36);
    sw_in = 8'hB6;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("glitch_deb", 32'(dut.sw_deb), 32'h36);
    end
    sw_in = 8'h36;
    tick(D + 4);
    check("glitch_after", 32'(dut.sw_deb), 32'h36);
    commit_round(8'h36, 0, "glitch_commit");

    // Timeout, then simultaneous pass+fail.
    commit_round(8'h5A, 3, "timeout");
    commit_round(8'hA5, 2, "both");

    // ena low mid-WAIT, dropped during the key_valid cycle.
    v = 8'($urandom);
    settle_sw(v);
    commit_btn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < D + 12 && !seen; i++) begin
      tick(1);
      if (key_valid === 1'b1) seen = 1'b1;
    end
    check("ena_kv_seen", 32'(seen), 32'd1);
    m_key = v;
    ena = 1'b0;
    #1;
    check("ena_kv_forced", 32'(key_valid), 32'd0);
    sw_in = ~v;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("ena_kv_low", 32'(key_valid), 32'd0);
      check_outs("ena_hold");
    end
    ena = 1'b1;
    sw_in = v;
    auth_pass = 1'b1;
    tick(1);
    auth_pass = 1'b0;
    model_verdict(0);
    check_outs("ena_pass");
    release_btn();

    // Three rejections lead to lockout; a commit during lockout is discarded.
    commit_round(8'h11, 1, "f1");
    commit_round(8'h22, 1, "f2");
    commit_round(8'h33, 1, "f3");
    k0 = kv_count;
    commit_btn = 1'b1;
    tick(10);
    release_btn();
    check("lock_commit_kv", 32'(kv_count - k0), 32'd0);
    check_outs("lock_mid");
    wait_lock_end("lock1");

    // Randomized rounds against the reference rules.
    for (int r = 0; r < 8; r++) begin
      commit_round(8'($urandom), int'($urandom_range(0, 3)), "rnd");
      if (m_lock) wait_lock_end("rnd");
    end
    if (m_fails != 0) commit_round(8'($urandom), 0, "rnd_clear");

    // Reset mid-lockout with the button held.
    commit_round(8'($urandom), 1, "r1");
    commit_round(8'($urandom), 2, "r2");
    commit_round(8'($urandom), 1, "r3");
    commit_btn = 1'b1;
    tick(5);
    #3;
    rst_n = 1'b0;
    #1;
    m_fails = 0;
    m_lock  = 1'b0;
    m_key   = 8'h00;
    check("async_rst_kv", 32'(key_valid), 32'd0);
    check_outs("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k0 = kv_count;
    tick(20);
    check("held_btn_kv", 32'(kv_count - k0), 32'd0);
    check_outs("held_btn");
    release_btn();
    check("released_kv", 32'(kv_count - k0), 32'd0);
    commit_round(8'($urandom), 0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
